// File: rtl/arm_mem_pkg.sv
// Shared definitions for the SRAM port arbiter.
//   state_t  : arbiter sequencing states
//   grant_t  : which pipeline port owns the current SRAM transaction
//   SRAM_AW  : SRAM word-address width (64-bit words)
//   SRAM_DW  : SRAM data-bus width
//   LANE_W   : width of one 32-bit lane inside an SRAM word
//   LANE_LO / LANE_HI : lane-select encodings (DQ[31:0] / DQ[63:32])
package arm_mem_pkg;

   localparam int SRAM_AW = 17;
   localparam int SRAM_DW = 64;
   localparam int LANE_W  = 32;

   localparam logic LANE_LO = 1'b0;
   localparam logic LANE_HI = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR,
      RESP
   } state_t;

   typedef enum logic {
      GNT_I,
      GNT_D
   } grant_t;

endpackage

// File: rtl/sram_lane_merge.sv
// Replaces one 32-bit lane of a 64-bit SRAM word, leaving the other lane
// untouched. Used to build the write-back word of a read-modify-write store.
//   word   : original 64-bit SRAM word
//   data   : 32-bit value to insert
//   lane   : LANE_LO -> bits [31:0], LANE_HI -> bits [63:32]
//   merged : resulting 64-bit word
module sram_lane_merge
   import arm_mem_pkg::*;
(
   input  logic [SRAM_DW-1:0] word,
   input  logic [LANE_W-1:0]  data,
   input  logic               lane,
   output logic [SRAM_DW-1:0] merged
);

   always_comb begin
      // NOTE: assigning a full default first keeps every path covered, so no latch is inferred.
      merged = word;
      if (lane == LANE_HI) begin
         merged[SRAM_DW-1:LANE_W] = data;
      end else begin
         merged[LANE_W-1:0] = data;
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one 64-bit asynchronous board SRAM between the IF-stage fetch port
// and the MEM-stage data port. Every transaction reads the addressed word for
// ACCESS_CYCLES cycles; stores then write the word back for ACCESS_CYCLES
// cycles with the selected 32-bit lane replaced (read-modify-write).
//
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   i_req, i_addr     : fetch request (held until i_ready) and byte address
//   i_ready, i_rdata  : one-cycle completion pulse and fetched word
//   d_rd_en, d_wr_en  : load / store request (store wins if both set)
//   d_addr, d_wdata   : data byte address and store data
//   d_ready, d_rdata  : low while a data access is pending; load data
//   SRAM_WE_N         : SRAM write enable, active-low
//   SRAM_ADDR         : SRAM 64-bit word address
//   SRAM_DQ           : bidirectional SRAM data bus
module sram_port_arbiter
   import arm_mem_pkg::*;
#(
   parameter int          ACCESS_CYCLES = 5,
   parameter logic [31:0] D_BASE        = 32'd1024,
   parameter logic [31:0] I_BASE        = 32'd0
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_req,
   input  logic [31:0]        i_addr,
   output logic               i_ready,
   output logic [31:0]        i_rdata,
   input  logic               d_rd_en,
   input  logic               d_wr_en,
   input  logic [31:0]        d_addr,
   input  logic [31:0]        d_wdata,
   output logic               d_ready,
   output logic [31:0]        d_rdata,
   output logic               SRAM_WE_N,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   inout  wire  [SRAM_DW-1:0] SRAM_DQ
);

   localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

   state_t              state;
   grant_t              gnt;
   logic                is_store;
   logic                lane;
   logic [LANE_W-1:0]   wdata_q;
   logic [CNT_W-1:0]    cnt;
   logic [SRAM_DW-1:0]  rbuf;
   logic [SRAM_AW-1:0]  addr_q;
   logic                we_n_q;
   logic                dq_oe;
   logic [LANE_W-1:0]   i_rdata_q;
   logic [LANE_W-1:0]   d_rdata_q;

   logic                d_req;
   logic [31:0]         d_off;
   logic [31:0]         i_off;
   logic [LANE_W-1:0]   rd_lane;
   logic [SRAM_DW-1:0]  wr_word;
   logic                unused_addr_bits;

   assign d_req = d_rd_en | d_wr_en;

   // Offsets wrap modulo 2^32; bits above the SRAM window and the byte
   // offset within a lane are dropped, so addresses alias every 1 MiB.
   assign d_off = d_addr - D_BASE;
   assign i_off = i_addr - I_BASE;
   assign unused_addr_bits = ^{d_off[31:20], d_off[1:0], i_off[31:20], i_off[1:0]};

   assign rd_lane = (lane == LANE_HI) ? SRAM_DQ[SRAM_DW-1:LANE_W] : SRAM_DQ[LANE_W-1:0];

   sram_lane_merge u_merge (
      .word   (rbuf),
      .data   (wdata_q),
      .lane   (lane),
      .merged (wr_word)
   );

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst) begin
         state     <= IDLE;
         gnt       <= GNT_I;
         is_store  <= 1'b0;
         lane      <= LANE_LO;
         wdata_q   <= '0;
         cnt       <= '0;
         rbuf      <= '0;
         addr_q    <= '0;
         we_n_q    <= 1'b1;
         dq_oe     <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (d_req) begin
                  gnt      <= GNT_D;
                  is_store <= d_wr_en;
                  addr_q   <= d_off[SRAM_AW+2:3];
                  lane     <= d_off[2];
                  wdata_q  <= d_wdata;
                  state    <= RD;
               end else if (i_req) begin
                  gnt      <= GNT_I;
                  is_store <= 1'b0;
                  addr_q   <= i_off[SRAM_AW+2:3];
                  lane     <= i_off[2];
                  state    <= RD;
               end
            end

            RD: begin
               if (cnt == CNT_LAST) begin
                  cnt  <= '0;
                  rbuf <= SRAM_DQ;
                  if (!is_store) begin
                     if (gnt == GNT_D) begin
                        d_rdata_q <= rd_lane;
                     end else begin
                        i_rdata_q <= rd_lane;
                     end
                  end
                  if (is_store) begin
                     // Bus drive and write enable switch on the same edge that
                     // ends the read phase, after the SRAM has released DQ.
                     we_n_q <= 1'b0;
                     dq_oe  <= 1'b1;
                     state  <= WR;
                  end else begin
                     state <= RESP;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            WR: begin
               if (cnt == CNT_LAST) begin
                  cnt    <= '0;
                  we_n_q <= 1'b1;
                  dq_oe  <= 1'b0;
                  state  <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            RESP: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign SRAM_ADDR = addr_q;
   assign SRAM_WE_N = we_n_q;
   assign SRAM_DQ   = dq_oe ? wr_word : {SRAM_DW{1'bz}};

   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;

   assign i_ready = (state == RESP) && (gnt == GNT_I);

   // The MEM stage stalls on any outstanding data request until its own RESP.
   assign d_ready = !(d_req && !((state == RESP) && (gnt == GNT_D)));

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

   localparam int          N      = 5;
   localparam logic [31:0] DBASE  = 32'd1024;
   localparam logic [31:0] IBASE  = 32'd0;
   localparam int          BUDGET = 40;

   typedef enum int {OP_LOAD, OP_STORE, OP_FETCH, OP_BOTH} op_t;

   typedef struct {
      op_t         op;
      logic        preload;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [63:0] init;
      logic [16:0] exp_addr;
      logic [31:0] exp_rdata;
      int          exp_lat;
      int          exp_we;
      logic [63:0] exp_wr;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ready;
   logic [31:0] i_rdata;
   logic        d_rd_en;
   logic        d_wr_en;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic        SRAM_WE_N;
   logic [16:0] SRAM_ADDR;
   wire  [63:0] SRAM_DQ;

   int total;
   int bad;

   // SRAM model: asynchronous read while WE_N is high, write sampled each clock WE_N is low.
   logic [63:0] mem [256];
   logic [63:0] ref_mem [256];
   logic        pl_en;
   logic [7:0]  pl_addr;
   logic [63:0] pl_data;

   assign SRAM_DQ = SRAM_WE_N ? mem[SRAM_ADDR[7:0]] : 64'bz;

   always @(posedge clk) begin
      if (!SRAM_WE_N) mem[SRAM_ADDR[7:0]] <= SRAM_DQ;
      else if (pl_en) mem[pl_addr] <= pl_data;
   end

   sram_port_arbiter #(
      .ACCESS_CYCLES (N),
      .D_BASE        (DBASE),
      .I_BASE        (IBASE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_ready   (i_ready),
      .i_rdata   (i_rdata),
      .d_rd_en   (d_rd_en),
      .d_wr_en   (d_wr_en),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ready   (d_ready),
      .d_rdata   (d_rdata),
      .SRAM_WE_N (SRAM_WE_N),
      .SRAM_ADDR (SRAM_ADDR),
      .SRAM_DQ   (SRAM_DQ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [7:0] a, input logic [63:0] v);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_data = v;
      next_cycle();
      pl_en   = 1'b0;
      ref_mem[a] = v;
   endtask

   // Reference: lane replacement by masking and shifting.
   function automatic logic [63:0] merge_ref(input logic [63:0] w, input logic [31:0] d, input int hi);
      logic [63:0] mask;
      mask = 64'hFFFF_FFFF << (hi * 32);
      return (w & ~mask) | ({32'b0, d} << (hi * 32));
   endfunction

   function automatic logic [31:0] lane_ref(input logic [63:0] w, input int hi);
      return 32'((w >> (hi * 32)) & 64'hFFFF_FFFF);
   endfunction

   // Issues one request at cycle 0 and follows it to its ready pulse.
   task automatic run_txn(input op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic [16:0] a_seen,
                          output int we_cnt, output int we_first, output logic [63:0] wr_word);
      lat = -1; rdata = '0; a_seen = '0; we_cnt = 0; we_first = -1; wr_word = '0;
      case (op)
         OP_LOAD:  begin d_rd_en = 1'b1; d_addr = addr; end
         OP_STORE: begin d_wr_en = 1'b1; d_addr = addr; d_wdata = wdata; end
         OP_BOTH:  begin d_rd_en = 1'b1; d_wr_en = 1'b1; d_addr = addr; d_wdata = wdata; end
         default:  begin i_req = 1'b1; i_addr = addr; end
      endcase
      for (int c = 0; c < BUDGET; c++) begin
         @(negedge clk);
         if (!SRAM_WE_N) begin
            if (we_first < 0) we_first = c;
            we_cnt++;
            wr_word = SRAM_DQ;
         end
         if ((op == OP_FETCH) ? i_ready : d_ready) begin
            lat    = c;
            rdata  = (op == OP_FETCH) ? i_rdata : d_rdata;
            a_seen = SRAM_ADDR;
            break;
         end
         next_cycle();
      end
      next_cycle();
      d_rd_en = 1'b0;
      d_wr_en = 1'b0;
      i_req   = 1'b0;
   endtask

   vec_t        vecs [9];
   int          lat, we_cnt, we_first;
   logic [31:0] rdata;
   logic [16:0] a_seen;
   logic [63:0] wr_word;

   initial begin
      int d_lat, i_lat, np, p0, p1, wl, ip, dl, nmis;
      logic [31:0] d_val, i_val, v;
      logic dr0, dr3;

      total = 0;
      bad   = 0;

      vecs[0] = '{OP_LOAD,  1'b1, 32'h0000_040C, 32'h0,          64'hAAAA_BBBB_1111_2222, 17'h1,     32'hAAAA_BBBB, 6,  0, 64'h0};
      vecs[1] = '{OP_STORE, 1'b1, 32'h0000_0408, 32'hDEAD_BEEF,  64'hAAAA_BBBB_1111_2222, 17'h1,     32'h0,         11, 5, 64'hAAAA_BBBB_DEAD_BEEF};
      vecs[2] = '{OP_LOAD,  1'b0, 32'h0000_0408, 32'h0,          64'h0,                   17'h1,     32'hDEAD_BEEF, 6,  0, 64'h0};
      vecs[3] = '{OP_FETCH, 1'b1, 32'h0000_0004, 32'h0,          64'h0123_4567_89AB_CDEF, 17'h0,     32'h0123_4567, 6,  0, 64'h0};
      vecs[4] = '{OP_LOAD,  1'b1, 32'h0010_0408, 32'h0,          64'h5555_6666_7777_8888, 17'h1,     32'h7777_8888, 6,  0, 64'h0};
      vecs[5] = '{OP_STORE, 1'b1, 32'h0000_041C, 32'hCAFE_F00D,  64'h1111_2222_3333_4444, 17'h3,     32'h0,         11, 5, 64'hCAFE_F00D_3333_4444};
      vecs[6] = '{OP_LOAD,  1'b1, 32'h0000_03FC, 32'h0,          64'h9999_AAAA_BBBB_CCCC, 17'h1FFFF, 32'h9999_AAAA, 6,  0, 64'h0};
      vecs[7] = '{OP_FETCH, 1'b1, 32'h0000_0010, 32'h0,          64'h0000_0001_0000_0002, 17'h2,     32'h0000_0002, 6,  0, 64'h0};
      vecs[8] = '{OP_BOTH,  1'b1, 32'h0000_0400, 32'h1234_5678,  64'hFFFF_FFFF_0000_0000, 17'h0,     32'h0,         11, 5, 64'hFFFF_FFFF_1234_5678};

      rst = 1'b0; i_req = 1'b0; i_addr = '0; d_rd_en = 1'b0; d_wr_en = 1'b0;
      d_addr = '0; d_wdata = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset we_n",    64'(SRAM_WE_N), 64'h1);
      check("reset addr",    64'(SRAM_ADDR), 64'h0);
      check("reset i_ready", 64'(i_ready),   64'h0);
      check("reset i_rdata", 64'(i_rdata),   64'h0);
      check("reset d_rdata", 64'(d_rdata),   64'h0);
      check("reset d_ready", 64'(d_ready),   64'h1);
      next_cycle();
      for (int i = 0; i < 256; i++) preload(8'(i), {$urandom, $urandom});
      rst = 1'b1;
      next_cycle();

      // Directed vectors.
      foreach (vecs[k]) begin
         if (vecs[k].preload) preload(vecs[k].exp_addr[7:0], vecs[k].init);
         run_txn(vecs[k].op, vecs[k].addr, vecs[k].wdata, lat, rdata, a_seen, we_cnt, we_first, wr_word);
         check($sformatf("vec%0d latency", k),   64'(lat),    64'(vecs[k].exp_lat));
         check($sformatf("vec%0d sram_addr", k), 64'(a_seen), 64'(vecs[k].exp_addr));
         check($sformatf("vec%0d we_cycles", k), 64'(we_cnt), 64'(vecs[k].exp_we));
         if (vecs[k].exp_we > 0) begin
            check($sformatf("vec%0d we_first", k), 64'(we_first), 64'(N + 1));
            check($sformatf("vec%0d dq_write", k), wr_word, vecs[k].exp_wr);
         end else begin
            check($sformatf("vec%0d rdata", k), 64'(rdata), 64'(vecs[k].exp_rdata));
         end
      end

      // Simultaneous fetch and load: data first. The fetch is granted from the
      // IDLE cycle after the data RESP, so it completes at 2N+3.
      preload(8'd0, 64'hFEDC_BA98_7654_3210);
      preload(8'd2, 64'h0BAD_0BAD_600D_600D);
      i_req = 1'b1; i_addr = 32'h4; d_rd_en = 1'b1; d_addr = 32'h410;
      d_lat = -1; i_lat = -1; d_val = '0; i_val = '0;
      for (int c = 0; c < BUDGET; c++) begin
         @(negedge clk);
         if (d_rd_en && d_ready && d_lat < 0) begin d_lat = c; d_val = d_rdata; end
         if (i_ready) begin i_lat = c; i_val = i_rdata; break; end
         next_cycle();
         if (d_lat >= 0) d_rd_en = 1'b0;
      end
      next_cycle();
      i_req = 1'b0; d_rd_en = 1'b0;
      check("prio d latency", 64'(d_lat), 64'(N + 1));
      check("prio d rdata",   64'(d_val), 64'h600D_600D);
      check("prio i latency", 64'(i_lat), 64'(2 * N + 3));
      check("prio i rdata",   64'(i_val), 64'hFEDC_BA98);

      // Back-to-back fetches with i_req held across RESP.
      preload(8'd5, 64'h1357_9BDF_2468_ACE0);
      i_req = 1'b1; i_addr = 32'h28;
      np = 0; p0 = -1; p1 = -1; v = '0;
      for (int c = 0; c <= 2 * N + 3; c++) begin
         @(negedge clk);
         if (i_ready) begin
            if (np == 0) p0 = c;
            else if (np == 1) p1 = c;
            np++;
            v = i_rdata;
         end
         next_cycle();
      end
      i_req = 1'b0;
      check("b2b pulses", 64'(np), 64'h2);
      check("b2b first",  64'(p0), 64'(N + 1));
      check("b2b second", 64'(p1), 64'(2 * N + 3));
      check("b2b rdata",  64'(v),  64'h2468_ACE0);

      // Load withdrawn mid-transaction still completes; a fetch raised meanwhile waits.
      preload(8'd6, 64'hA1A1_B2B2_C3C3_D4D4);
      d_rd_en = 1'b1; d_addr = 32'h430;
      i_lat = -1; i_val = '0; dr0 = 1'b1; dr3 = 1'b0;
      for (int c = 0; c < BUDGET; c++) begin
         @(negedge clk);
         if (c == 0) dr0 = d_ready;
         if (c == 3) dr3 = d_ready;
         if (i_ready) begin i_lat = c; i_val = i_rdata; break; end
         next_cycle();
         if (c == 1) begin d_rd_en = 1'b0; i_req = 1'b1; i_addr = 32'h34; end
      end
      next_cycle();
      i_req = 1'b0;
      check("drop d_ready pending", 64'(dr0),     64'h0);
      check("drop d_ready idle",    64'(dr3),     64'h1);
      check("drop i latency",       64'(i_lat),   64'(2 * N + 3));
      check("drop i rdata",         64'(i_val),   64'hA1A1_B2B2);
      check("drop d rdata",         64'(d_rdata), 64'hC3C3_D4D4);

      // Reset asserted during the write phase of a store.
      preload(8'd7, 64'h7777_0000_EEEE_1111);
      d_wr_en = 1'b1; d_addr = 32'h43C; d_wdata = 32'h5A5A_5A5A;
      for (int c = 0; c < N + 3; c++) begin
         @(negedge clk);
         next_cycle();
      end
      rst = 1'b0; d_wr_en = 1'b0;
      @(negedge clk);
      check("rstwr we_n before edge", 64'(SRAM_WE_N), 64'h0);
      next_cycle();
      @(negedge clk);
      check("rstwr we_n",    64'(SRAM_WE_N), 64'h1);
      check("rstwr addr",    64'(SRAM_ADDR), 64'h0);
      check("rstwr i_ready", 64'(i_ready),   64'h0);
      check("rstwr i_rdata", 64'(i_rdata),   64'h0);
      check("rstwr d_rdata", 64'(d_rdata),   64'h0);
      check("rstwr d_ready", 64'(d_ready),   64'h1);
      next_cycle();
      rst = 1'b1;
      wl = 0; ip = 0; dl = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (!SRAM_WE_N) wl++;
         if (i_ready) ip++;
         if (!d_ready) dl++;
         next_cycle();
      end
      check("post-reset we_n low cycles", 64'(wl), 64'h0);
      check("post-reset i_ready pulses",  64'(ip), 64'h0);
      check("post-reset d_ready low",     64'(dl), 64'h0);
      run_txn(OP_LOAD, 32'h438, 32'h0, lat, rdata, a_seen, we_cnt, we_first, wr_word);
      check("post-reset load latency", 64'(lat),   64'(N + 1));
      check("post-reset load rdata",   64'(rdata), 64'hEEEE_1111);

      // Randomized transactions against a transaction-level memory model.
      for (int i = 0; i < 256; i++) preload(8'(i), {$urandom, $urandom});
      for (int t = 0; t < 60; t++) begin
         op_t         op;
         int          off, w, hi, gap;
         logic [31:0] a, wd;
         op  = op_t'($urandom_range(0, 2));
         off = int'($urandom_range(0, 2047));
         wd  = $urandom;
         w   = off / 8;
         hi  = (off / 4) % 2;
         a   = (op == OP_FETCH) ? IBASE + 32'(off) : DBASE + 32'(off);
         run_txn(op, a, wd, lat, rdata, a_seen, we_cnt, we_first, wr_word);
         check($sformatf("rnd%0d sram_addr", t), 64'(a_seen), 64'(w));
         if (op == OP_STORE) begin
            check($sformatf("rnd%0d latency", t),   64'(lat),    64'(2 * N + 1));
            check($sformatf("rnd%0d we_cycles", t), 64'(we_cnt), 64'(N));
            check($sformatf("rnd%0d dq_write", t),  wr_word,     merge_ref(ref_mem[w], wd, hi));
            ref_mem[w] = merge_ref(ref_mem[w], wd, hi);
         end else begin
            check($sformatf("rnd%0d latency", t),   64'(lat),    64'(N + 1));
            check($sformatf("rnd%0d we_cycles", t), 64'(we_cnt), 64'h0);
            check($sformatf("rnd%0d rdata", t),     64'(rdata),  64'(lane_ref(ref_mem[w], hi)));
         end
         gap = int'($urandom_range(0, 2));
         repeat (gap) next_cycle();
      end

      nmis = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nmis++;
      check("final memory image mismatching words", 64'(nmis), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
